// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Main controller for the multicycle RISC-V datapath. Steps each
//             instruction through fetch / decode / execute / memory /
//             writeback states and drives the datapath selects and strobes.
//             Memory accesses use a mem_req/mem_ready handshake with an
//             optional wait timeout. Illegal opcodes and timeouts lock the
//             FSM in a sticky TRAP state until reset.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             Opcode, Zero        - instr[6:0] (read in DECODE), ALU zero flag
//             mem_ready, mem_req  - memory handshake
//             PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
//             ResultSrc, ALUSrcA, ALUSrcB, ALUOp - datapath control
//             trap, trap_cause    - sticky trap flag and cause (01 illegal,
//                                   10 memory timeout)
//             state               - current state encoding (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter bit ENABLE_JAL  = 1'b1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic [6:0] Opcode,
   input  wire logic       Zero,
   input  wire logic       mem_ready,
   output logic            mem_req,
   output logic            PCWrite,
   output logic            AdrSrc,
   output logic            IRWrite,
   output logic            MemWrite,
   output logic            RegWrite,
   output logic [1:0]      ResultSrc,
   output logic [1:0]      ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      ALUOp,
   output logic            trap,
   output logic [1:0]      trap_cause,
   output logic [3:0]      state
);

   // Counter must be able to hold MEM_TIMEOUT itself; keep at least 1 bit
   // so the disabled configuration still elaborates.
   localparam int c_cnt_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(MEM_TIMEOUT);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_TRAP     = 4'd11
   } state_e;

   state_e               state_q, state_d;
   logic                 opb5_q, opb5_d;     // Opcode[5]: store vs load
   logic [1:0]           cause_q, cause_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;
   logic                 w_wait_state;
   logic                 w_timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         opb5_q  <= 1'b0;
         cause_q <= 2'b00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opb5_q  <= opb5_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. A completing access (mem_ready=1) always beats the
   // timeout, since w_timeout is qualified with !mem_ready.
   always_comb begin
      state_d      = state_q;
      opb5_d       = opb5_q;
      cause_d      = cause_q;
      w_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);
      w_timeout    = (MEM_TIMEOUT != 0) && (cnt_q == c_timeout) && !mem_ready;

      // Any exit from a wait state (or any other state) clears the counter,
      // so it always starts from 0 on entry to the next wait state.
      if (w_wait_state && !mem_ready && !w_timeout && (MEM_TIMEOUT != 0))
         cnt_d = cnt_q + 1'b1;
      else
         cnt_d = '0;

      case (state_q)
         S_FETCH: begin
            if (mem_ready)      state_d = S_DECODE;
            else if (w_timeout) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end
         end
         S_DECODE: begin
            opb5_d = Opcode[5];
            case (Opcode)
               7'b0000011,
               7'b0100011: state_d = S_MEMADR;
               7'b0110011: state_d = S_EXECR;
               7'b0010011: state_d = S_EXECI;
               7'b1100011: state_d = S_BEQ;
               7'b1101111: begin
                  if (ENABLE_JAL) state_d = S_JAL;
                  else begin
                     state_d = S_TRAP;
                     cause_d = 2'b01;
                  end
               end
               default: begin
                  state_d = S_TRAP;
                  cause_d = 2'b01;
               end
            endcase
         end
         S_MEMADR:   state_d = opb5_q ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD,
         S_MEMWRITE: begin
            if (mem_ready)
               state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
            else if (w_timeout) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end
         end
         S_MEMWB:    state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_BEQ:      state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore outputs; PCWrite/IRWrite additionally qualified by mem_ready or
   // Zero. Everything is forced low while rst is held so that an aborted
   // instruction cannot fire a strobe in the reset cycle.
   always_comb begin
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      trap       = 1'b0;
      trap_cause = 2'b00;
      state      = 4'd0;
      if (!rst) begin
         state = state_q;
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
            end
            S_DECODE: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
               mem_req = 1'b1;
               AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
               ResultSrc = 2'b01;
               RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
               mem_req  = 1'b1;
               AdrSrc   = 1'b1;
               MemWrite = 1'b1;
            end
            S_EXECR: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b10;
            end
            S_EXECI: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ALUOp   = 2'b10;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_JAL: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               PCWrite = 1'b1;
            end
            S_BEQ: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b01;
               PCWrite = Zero;
            end
            S_TRAP: begin
               trap       = 1'b1;
               trap_cause = cause_q;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Self-checking bench for multicycle_control. Two instances:
//             A (MEM_TIMEOUT=16, JAL enabled) and B (MEM_TIMEOUT=4, JAL
//             disabled). A fixed vector table, hand sequences for traps,
//             timeouts and reset, and randomized instruction streams checked
//             against a per-instruction-class cycle model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] c_lw   = 7'b0000011;
   localparam logic [6:0] c_sw   = 7'b0100011;
   localparam logic [6:0] c_rtyp = 7'b0110011;
   localparam logic [6:0] c_itype= 7'b0010011;
   localparam logic [6:0] c_beq  = 7'b1100011;
   localparam logic [6:0] c_jal  = 7'b1101111;

   // ---------------- instance A ----------------
   logic a_rst = 1'b1, a_zero = 1'b0, a_rdy = 1'b0;
   logic [6:0] a_op = 7'd0;
   wire logic a_mreq, a_pcw, a_adr, a_irw, a_mw, a_rw, a_trap;
   wire logic [1:0] a_rs, a_sa, a_sb, a_aop, a_tc;
   wire logic [3:0] a_st;
   wire logic [20:0] out_a = {a_mreq, a_pcw, a_adr, a_irw, a_mw, a_rw, a_rs,
                              a_sa, a_sb, a_aop, a_trap, a_tc, a_st};

   multicycle_control #(.MEM_TIMEOUT(16), .ENABLE_JAL(1'b1)) dut_a (
      .clk(clk), .rst(a_rst), .Opcode(a_op), .Zero(a_zero),
      .mem_ready(a_rdy), .mem_req(a_mreq), .PCWrite(a_pcw), .AdrSrc(a_adr),
      .IRWrite(a_irw), .MemWrite(a_mw), .RegWrite(a_rw), .ResultSrc(a_rs),
      .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_aop), .trap(a_trap),
      .trap_cause(a_tc), .state(a_st));

   // ---------------- instance B ----------------
   logic b_rst = 1'b1, b_zero = 1'b0, b_rdy = 1'b0;
   logic [6:0] b_op = 7'd0;
   wire logic b_mreq, b_pcw, b_adr, b_irw, b_mw, b_rw, b_trap;
   wire logic [1:0] b_rs, b_sa, b_sb, b_aop, b_tc;
   wire logic [3:0] b_st;
   wire logic [20:0] out_b = {b_mreq, b_pcw, b_adr, b_irw, b_mw, b_rw, b_rs,
                              b_sa, b_sb, b_aop, b_trap, b_tc, b_st};

   multicycle_control #(.MEM_TIMEOUT(4), .ENABLE_JAL(1'b0)) dut_b (
      .clk(clk), .rst(b_rst), .Opcode(b_op), .Zero(b_zero),
      .mem_ready(b_rdy), .mem_req(b_mreq), .PCWrite(b_pcw), .AdrSrc(b_adr),
      .IRWrite(b_irw), .MemWrite(b_mw), .RegWrite(b_rw), .ResultSrc(b_rs),
      .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_aop), .trap(b_trap),
      .trap_cause(b_tc), .state(b_st));

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int passed = 0;
   bit sel = 1'b0;                 // 0 = instance A, 1 = instance B

   typedef struct {
      logic [3:0] st;
      logic       rdy;
      logic [1:0] cause;
   } cyc_t;
   cyc_t       q[$];
   logic [6:0] plan_op;
   bit         plan_trapped;

   typedef struct packed {
      logic [6:0]      op;
      logic            z;
      logic [3:0]      n;
      logic [0:7][3:0] st;
      logic [0:7]      rdy;
   } vec_t;
   vec_t tbl[9];

   // Expected output vector for a state, straight from the per-state table.
   function automatic logic [20:0] exp_out(input logic [3:0] st, input logic rdy,
                                           input logic z, input logic [1:0] cause);
      logic mreq, pcw, adr, irw, mw, rw, tr;
      logic [1:0] rs, sa, sb, aop, tc;
      mreq = 0; pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; tr = 0;
      rs = 0; sa = 0; sb = 0; aop = 0; tc = 0;
      case (st)
         4'd0:  begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
         4'd1:  begin sa = 2'b01; sb = 2'b01; end
         4'd2:  begin sa = 2'b10; sb = 2'b01; end
         4'd3:  begin mreq = 1; adr = 1; end
         4'd4:  begin rs = 2'b01; rw = 1; end
         4'd5:  begin mreq = 1; adr = 1; mw = 1; end
         4'd6:  begin sa = 2'b10; aop = 2'b10; end
         4'd7:  begin rw = 1; end
         4'd8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         4'd9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         4'd10: begin sa = 2'b10; aop = 2'b01; pcw = z; end
         4'd11: begin tr = 1; tc = cause; end
         default: ;
      endcase
      return {mreq, pcw, adr, irw, mw, rw, rs, sa, sb, aop, tr, tc, st};
   endfunction

   function automatic logic [20:0] get_out();
      return sel ? out_b : out_a;
   endfunction

   task automatic drive(input logic r, input logic [6:0] op, input logic z,
                        input logic rdy);
      if (!sel) begin a_rst = r; a_op = op; a_zero = z; a_rdy = rdy; end
      else      begin b_rst = r; b_op = op; b_zero = z; b_rdy = rdy; end
   endtask

   // Compare, then advance to #1 after the next rising edge.
   task automatic check_step(input string name, input logic [20:0] exp);
      logic [20:0] act;
      #1;
      act = get_out();
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s (dut %0d): got %h expected %h (state got %0d exp %0d)",
                    name, sel, act, exp, act[3:0], exp[3:0]);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 7'($urandom), 1'($urandom), 1'b1);
      check_step("reset", 21'd0);
   endtask

   // ---------------- reference model: per-class cycle plan ----------------
   task automatic push(input logic [3:0] st, input logic rdy, input logic [1:0] cause);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.cause = cause;
      q.push_back(c);
   endtask

   // A wait state with w not-ready cycles: completes if w <= T, otherwise the
   // (T+1)th consecutive not-ready cycle is the last one before TRAP.
   task automatic wait_phase(input logic [3:0] st, input int w, input int t);
      if (t != 0 && w > t) begin
         repeat (t + 1) push(st, 1'b0, 2'b00);
         plan_trapped = 1'b1;
      end else begin
         repeat (w) push(st, 1'b0, 2'b00);
         push(st, 1'b1, 2'b00);
      end
   endtask

   task automatic trap_tail(input logic [1:0] cause, input int hold);
      plan_trapped = 1'b1;
      repeat (hold + 1) push(4'd11, 1'($urandom), cause);
   endtask

   task automatic plan(input logic [6:0] op, input int fw, input int mw, input int hold);
      int t;
      bit jal_en;
      t      = sel ? 4 : 16;
      jal_en = !sel;
      plan_op = op;
      plan_trapped = 1'b0;
      wait_phase(4'd0, fw, t);
      if (plan_trapped) begin trap_tail(2'b10, hold); return; end
      push(4'd1, 1'($urandom), 2'b00);
      if (op == c_lw || op == c_sw) begin
         push(4'd2, 1'($urandom), 2'b00);
         wait_phase((op == c_lw) ? 4'd3 : 4'd5, mw, t);
         if (plan_trapped) trap_tail(2'b10, hold);
         else if (op == c_lw) push(4'd4, 1'($urandom), 2'b00);
      end else if (op == c_rtyp) begin
         push(4'd6, 1'($urandom), 2'b00); push(4'd7, 1'($urandom), 2'b00);
      end else if (op == c_itype) begin
         push(4'd8, 1'($urandom), 2'b00); push(4'd7, 1'($urandom), 2'b00);
      end else if (op == c_jal && jal_en) begin
         push(4'd9, 1'($urandom), 2'b00); push(4'd7, 1'($urandom), 2'b00);
      end else if (op == c_beq) begin
         push(4'd10, 1'($urandom), 2'b00);
      end else begin
         trap_tail(2'b01, hold);
      end
   endtask

   // Opcode is only presented correctly in DECODE; garbage elsewhere.
   task automatic run(input int limit);
      cyc_t c;
      logic z;
      int n;
      n = 0;
      while (q.size() > 0 && n < limit) begin
         c = q.pop_front();
         z = 1'($urandom);
         drive(1'b0, (c.st == 4'd1) ? plan_op : 7'($urandom), z, c.rdy);
         check_step($sformatf("plan_st%0d", c.st), exp_out(c.st, c.rdy, z, c.cause));
         n++;
      end
      q.delete();
   endtask

   function automatic logic [6:0] rand_op();
      case ($urandom_range(0, 12))
         0, 1:    return c_lw;
         2, 3:    return c_sw;
         4, 5:    return c_rtyp;
         6, 7:    return c_itype;
         8, 9:    return c_beq;
         10, 11:  return c_jal;
         default: return 7'($urandom);
      endcase
   endfunction

   task automatic random_stream(input int count, input int maxw);
      for (int i = 0; i < count; i++) begin
         plan(rand_op(), $urandom_range(0, maxw), $urandom_range(0, maxw), 2);
         run(1000);
         if (plan_trapped) do_reset();
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      tbl[0] = '{c_rtyp,  1'b0, 4'd4, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0,4'd0,4'd0}, 8'b1111_1111};
      tbl[1] = '{c_lw,    1'b0, 4'd7, {4'd0,4'd1,4'd2,4'd3,4'd3,4'd3,4'd4,4'd0}, 8'b1110_0111};
      tbl[2] = '{c_sw,    1'b0, 4'd4, {4'd0,4'd1,4'd2,4'd5,4'd0,4'd0,4'd0,4'd0}, 8'b1111_1111};
      tbl[3] = '{c_itype, 1'b0, 4'd4, {4'd0,4'd1,4'd8,4'd7,4'd0,4'd0,4'd0,4'd0}, 8'b1111_1111};
      tbl[4] = '{c_jal,   1'b0, 4'd4, {4'd0,4'd1,4'd9,4'd7,4'd0,4'd0,4'd0,4'd0}, 8'b1111_1111};
      tbl[5] = '{c_beq,   1'b1, 4'd3, {4'd0,4'd1,4'd10,4'd0,4'd0,4'd0,4'd0,4'd0}, 8'b1111_1111};
      tbl[6] = '{c_beq,   1'b0, 4'd3, {4'd0,4'd1,4'd10,4'd0,4'd0,4'd0,4'd0,4'd0}, 8'b1111_1111};
      tbl[7] = '{c_rtyp,  1'b0, 4'd5, {4'd0,4'd0,4'd1,4'd6,4'd7,4'd0,4'd0,4'd0}, 8'b0111_1111};
      tbl[8] = '{c_sw,    1'b1, 4'd5, {4'd0,4'd1,4'd2,4'd5,4'd5,4'd0,4'd0,4'd0}, 8'b1000_1111};

      @(posedge clk);
      #1;
      // ---- instance A ----
      sel = 1'b0;
      do_reset();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         for (int k = 0; k < int'(tbl[i].n); k++) begin
            drive(1'b0, (tbl[i].st[k] == 4'd1) ? tbl[i].op : 7'($urandom),
                  tbl[i].z, tbl[i].rdy[k]);
            check_step($sformatf("vec%0d_cyc%0d", i, k),
                       exp_out(tbl[i].st[k], tbl[i].rdy[k], tbl[i].z, 2'b00));
         end
      end
      // Illegal opcode: sticky trap held for 20 cycles, then reset.
      plan(7'b1111111, 0, 0, 20);
      run(1000);
      do_reset();
      // Reset asserted while waiting in MEMREAD aborts the load.
      plan(c_lw, 0, 3, 0);
      run(5);
      do_reset();
      plan(c_rtyp, 0, 0, 0);
      run(1000);
      random_stream(150, 3);

      // ---- instance B ----
      a_rst = 1'b1;
      sel   = 1'b1;
      do_reset();
      plan(c_rtyp, 10, 0, 3);   // FETCH timeout
      run(1000);
      do_reset();
      plan(c_rtyp, 4, 0, 0);    // ready on the boundary cycle completes
      run(1000);
      plan(c_jal, 0, 0, 3);     // JAL disabled -> illegal
      run(1000);
      do_reset();
      plan(c_sw, 0, 7, 3);      // MEMWRITE timeout
      run(1000);
      do_reset();
      plan(c_lw, 1, 4, 0);      // MEMREAD boundary completes
      run(1000);
      random_stream(60, 6);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Absolute safety net in case something stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passed);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
